pc_sequencer: RTL and testbench

Program-counter sequencer that consumes the ALU's Zero flag and issues the next instruction address each cycle. It resolves unconditional jumps and zero-conditioned branches (the JEQ/SLT/SEQ compare results) through a small branch-target lookup table. It also manages the Start/Done run handshake with the testbench/host and counts executed cycles. It sits between the control decoder/ALU and instruction memory in the single-cycle core.

---
 rtl/pc_sequencer_pkg.sv | 26 ++
 rtl/branch_lut.sv | 18 +
 rtl/pc_sequencer.sv | 109 ++++++++++
 tb/tb_pc_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: FSM state encoding,
// default widths and the constant branch-target table read by branch_lut.
package pc_sequencer_pkg;

  localparam int unsigned PCS_PC_W      = 10;
  localparam int unsigned PCS_LUT_AW    = 5;
  localparam int unsigned PCS_CNT_W     = 16;
  localparam int unsigned PCS_LUT_DEPTH = 1 << PCS_LUT_AW;

  typedef enum logic [1:0] {
    PCS_IDLE = 2'd0,
    PCS_RUN  = 2'd1,
    PCS_DONE = 2'd2
  } pcs_state_t;

  typedef logic [PCS_PC_W-1:0] pcs_addr_t;

  // Absolute branch/jump targets indexed by the instruction's LUT field.
  localparam pcs_addr_t kBranchTargets [PCS_LUT_DEPTH] = '{
    0:       10'h000,
    3:       10'h040,
    5:       10'h3FF,
    default: 10'h000
  };

endpackage : pc_sequencer_pkg

// File: rtl/branch_lut.sv
// Combinational branch-target lookup.
// Ports:
//   LutIdx  - table index taken from the instruction field
//   Target  - absolute target address for that index
module branch_lut
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned PC_W   = PCS_PC_W,
  parameter int unsigned LUT_AW = PCS_LUT_AW
) (
  input  logic [LUT_AW-1:0] LutIdx,
  output logic [PC_W-1:0]   Target
);

  // Table entries are stored at the package width; resize to the local PC width.
  assign Target = PC_W'(kBranchTargets[LutIdx]);

endmodule : branch_lut

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the single-cycle core. Issues the next
// instruction address every RUN cycle (sequential, jump, or zero-taken branch),
// runs the Start/Done handshake with the host and counts RUN cycles.
// Ports:
//   Clk, Reset      - clock, synchronous active-high reset
//   Start/StartAddr - begin a program at StartAddr (accepted in IDLE or DONE)
//   Halt/Jump/BranchZ/Zero/LutIdx - decoded control for the current PC
//   PC              - current instruction address
//   Running/Done    - RUN / DONE state flags
//   CycleCount      - saturating count of RUN cycles for the current program
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned PC_W   = PCS_PC_W,
  parameter int unsigned LUT_AW = PCS_LUT_AW,
  parameter int unsigned CNT_W  = PCS_CNT_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [PC_W-1:0]   StartAddr,
  input  logic              Halt,
  input  logic              Jump,
  input  logic              BranchZ,
  input  logic              Zero,
  input  logic [LUT_AW-1:0] LutIdx,
  output logic [PC_W-1:0]   PC,
  output logic              Running,
  output logic              Done,
  output logic [CNT_W-1:0]  CycleCount
);

  pcs_state_t       state_q;
  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  pc_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             running_q;
  logic             done_q;
  logic [PC_W-1:0]  lut_target;

  branch_lut #(
    .PC_W   (PC_W),
    .LUT_AW (LUT_AW)
  ) u_branch_lut (
    .LutIdx (LutIdx),
    .Target (lut_target)
  );

  // Next PC while running; Halt is resolved in the FSM and takes precedence.
  always_comb begin
    pc_d = pc_q + PC_W'(1);
    if (Jump || (BranchZ && Zero)) begin
      pc_d = lut_target;
    end
  end

  // Saturating cycle counter increment.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Sequencer FSM; control inputs are only looked at in RUN so X elsewhere is harmless.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= PCS_IDLE;
      pc_q      <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        PCS_IDLE, PCS_DONE: begin
          if (Start) begin
            state_q   <= PCS_RUN;
            pc_q      <= StartAddr;
            cnt_q     <= '0;
            running_q <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        PCS_RUN: begin
          cnt_q <= cnt_d;
          if (Halt) begin
            state_q   <= PCS_DONE;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            pc_q <= pc_d;
          end
        end
        default: begin
          state_q   <= PCS_IDLE;
          running_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign PC         = pc_q;
  assign Running    = running_q;
  assign Done       = done_q;
  assign CycleCount = cnt_q;

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: the driver pushes the hand-computed
// post-edge state for every cycle it issues, a monitor pops and compares.
// A second instance with a 4-bit counter exercises saturation.
module tb_pc_sequencer;

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic [9:0] StartAddr;
  logic       Halt;
  logic       Jump;
  logic       BranchZ;
  logic       Zero;
  logic [4:0] LutIdx;
  logic [9:0] PC;
  logic       Running;
  logic       Done;
  logic [15:0] CycleCount;

  logic       reset2;
  logic       start2;
  logic [9:0] pc2;
  logic       running2;
  logic       done2;
  logic [3:0] cnt2;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    string       name;
    logic [9:0]  pc;
    logic        run;
    logic        done;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  pc_sequencer dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .StartAddr  (StartAddr),
    .Halt       (Halt),
    .Jump       (Jump),
    .BranchZ    (BranchZ),
    .Zero       (Zero),
    .LutIdx     (LutIdx),
    .PC         (PC),
    .Running    (Running),
    .Done       (Done),
    .CycleCount (CycleCount)
  );

  pc_sequencer #(.PC_W(10), .LUT_AW(5), .CNT_W(4)) dut_sat (
    .Clk        (Clk),
    .Reset      (reset2),
    .Start      (start2),
    .StartAddr  (10'h000),
    .Halt       (1'b0),
    .Jump       (1'b0),
    .BranchZ    (1'b0),
    .Zero       (1'b0),
    .LutIdx     (5'd0),
    .PC         (pc2),
    .Running    (running2),
    .Done       (done2),
    .CycleCount (cnt2)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Advance one edge with the inputs already applied, then record what must follow.
  task automatic cyc(input string n, input logic [9:0] pc, input logic r,
                     input logic d, input logic [15:0] c);
    exp_t e;
    @(posedge Clk);
    #1;
    e.name = n;
    e.pc   = pc;
    e.run  = r;
    e.done = d;
    e.cnt  = c;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are presented every cycle; compare whenever an expectation is pending.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests_run++;
        if (PC !== e.pc || Running !== e.run || Done !== e.done || CycleCount !== e.cnt) begin
          tests_failed++;
          $display("FAIL %s: got pc=%h run=%b done=%b cnt=%0d, expected pc=%h run=%b done=%b cnt=%0d",
                   e.name, PC, Running, Done, CycleCount, e.pc, e.run, e.done, e.cnt);
        end
      end
    end
  end

  initial begin
    Reset = 1'b1; Start = 1'b0; StartAddr = '0; Halt = 1'b0; Jump = 1'b0;
    BranchZ = 1'b0; Zero = 1'b0; LutIdx = '0;
    reset2 = 1'b1; start2 = 1'b0;

    cyc("reset", 10'h000, 0, 0, 0);
    Reset = 1'b0; Jump = 1'b1; LutIdx = 5'd3;
    cyc("idle_ignores_ctrl", 10'h000, 0, 0, 0);
    Jump = 1'b0;

    // Basic sequential run
    Start = 1'b1; StartAddr = 10'h010;
    cyc("start", 10'h010, 1, 0, 0);
    Start = 1'b0;
    cyc("seq1", 10'h011, 1, 0, 1);
    cyc("seq2", 10'h012, 1, 0, 2);
    cyc("seq3", 10'h013, 1, 0, 3);

    // Jump / branch / wrap
    Reset = 1'b1;
    cyc("reset2", 10'h000, 0, 0, 0);
    Reset = 1'b0; Start = 1'b1; StartAddr = 10'h020;
    cyc("start_020", 10'h020, 1, 0, 0);
    Start = 1'b0; Jump = 1'b1; LutIdx = 5'd3;
    cyc("jump_lut3", 10'h040, 1, 0, 1);
    Jump = 1'b0; BranchZ = 1'b1; Zero = 1'b0;
    cyc("branch_not_taken", 10'h041, 1, 0, 2);
    Zero = 1'b1; LutIdx = 5'd5;
    cyc("branch_taken", 10'h3FF, 1, 0, 3);
    BranchZ = 1'b0; Zero = 1'b0;
    cyc("pc_wrap", 10'h000, 1, 0, 4);
    Start = 1'b1; StartAddr = 10'h100;
    cyc("start_ignored_in_run", 10'h001, 1, 0, 5);
    Start = 1'b0; Zero = 1'b1;
    cyc("zero_without_branch", 10'h002, 1, 0, 6);
    Zero = 1'b0; Jump = 1'b1; LutIdx = 5'd0;
    cyc("jump_lut0", 10'h000, 1, 0, 7);
    Jump = 1'b0;
    cyc("after_jump0", 10'h001, 1, 0, 8);

    // Halt wins over Jump, then DONE holds
    Reset = 1'b1;
    cyc("reset3", 10'h000, 0, 0, 0);
    Reset = 1'b0; Start = 1'b1; StartAddr = 10'h000;
    cyc("start_000", 10'h000, 1, 0, 0);
    Start = 1'b0;
    for (int i = 1; i <= 5; i++) cyc("run_to_5", 10'(i), 1, 0, 16'(i));
    Halt = 1'b1; Jump = 1'b1; LutIdx = 5'd3;
    cyc("halt_over_jump", 10'h005, 0, 1, 6);
    Halt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      BranchZ = i[0]; Zero = 1'b1; Jump = i[1];
      cyc("done_hold", 10'h005, 0, 1, 6);
    end
    Jump = 1'b0; BranchZ = 1'b0; Zero = 1'b0;

    // Restart from DONE
    Start = 1'b1; StartAddr = 10'h100;
    cyc("restart_from_done", 10'h100, 1, 0, 0);
    Start = 1'b0;
    cyc("restart_seq", 10'h101, 1, 0, 1);

    // Reset mid-RUN beats a simultaneous jump, and beats Start
    Reset = 1'b1;
    cyc("reset4", 10'h000, 0, 0, 0);
    Reset = 1'b0; Start = 1'b1; StartAddr = 10'h030;
    cyc("start_030", 10'h030, 1, 0, 0);
    Start = 1'b0;
    cyc("run_031", 10'h031, 1, 0, 1);
    cyc("run_032", 10'h032, 1, 0, 2);
    cyc("run_033", 10'h033, 1, 0, 3);
    Reset = 1'b1; Jump = 1'b1; LutIdx = 5'd3;
    cyc("reset_mid_run", 10'h000, 0, 0, 0);
    Jump = 1'b0; Start = 1'b1; StartAddr = 10'h100;
    cyc("reset_beats_start", 10'h000, 0, 0, 0);
    Reset = 1'b0; Start = 1'b0;
    cyc("idle_after_reset", 10'h000, 0, 0, 0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge Clk);
    #3;
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    // Saturation on the 4-bit counter instance
    @(posedge Clk); #1;
    reset2 = 1'b0; start2 = 1'b1;
    @(posedge Clk); #1;
    start2 = 1'b0;
    tests_run++;
    if (running2 !== 1'b1 || cnt2 !== 4'd0) begin
      tests_failed++;
      $display("FAIL sat_start: got run=%b cnt=%0d, expected run=1 cnt=0", running2, cnt2);
    end
    for (int i = 1; i <= 20; i++) begin
      @(posedge Clk); #1;
      tests_run++;
      if (cnt2 !== 4'((i > 15) ? 15 : i)) begin
        tests_failed++;
        $display("FAIL sat_count[%0d]: got %0d, expected %0d", i, cnt2, (i > 15) ? 15 : i);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_pc_sequencer
